// File: rtl/song_reader.sv
// Song sequencer: walks the selected song's note list in a synchronous ROM and
// hands each note to the note player with a new_note / note_done handshake.
module song_reader #(
  parameter int NOTES_PER_SONG = 32,
  parameter int NOTE_W         = 6,
  parameter int DUR_W          = 6,
  localparam int IDX_W         = $clog2(NOTES_PER_SONG)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic                     reset_player,
  input  logic [1:0]               song,
  output logic [IDX_W+1:0]         rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]  rom_data,
  input  logic                     note_done,
  output logic [NOTE_W-1:0]        note,
  output logic [DUR_W-1:0]         duration,
  output logic                     new_note,
  output logic                     song_done
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH     = 3'd1;
  localparam logic [2:0] LATCH     = 3'd2;
  localparam logic [2:0] WAIT_NOTE = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES_PER_SONG - 1);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        song_q;
  logic [NOTE_W-1:0] note_d;
  logic [DUR_W-1:0]  dur_d;
  logic              new_note_d;
  logic              song_done_d;
  logic              restart;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  assign rom_addr = {song, idx_q};
  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  // A song change is treated exactly like an explicit restart request.
  assign restart = reset_player || (song != song_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    note_d      = note;
    dur_d       = duration;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;
    if (restart) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (play) state_d = FETCH;
        end
        FETCH: begin
          state_d = LATCH;
        end
        LATCH: begin
          // A zero duration marks the end of a song shorter than the full slot count.
          if (rom_dur != '0) begin
            note_d     = rom_note;
            dur_d      = rom_dur;
            new_note_d = 1'b1;
            state_d    = WAIT_NOTE;
          end else begin
            song_done_d = 1'b1;
            state_d     = DONE;
          end
        end
        WAIT_NOTE: begin
          if (play && note_done) begin
            if (idx_q == LAST_IDX) begin
              idx_d       = '0;
              song_done_d = 1'b1;
              state_d     = DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = FETCH;
            end
          end
        end
        DONE: begin
          // Wait for play to drop so the mcu can react before any replay.
          if (!play) begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          idx_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    song_q <= song;
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      note      <= note_d;
      duration  <= dur_d;
      new_note  <= new_note_d;
      song_done <= song_done_d;
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader with a behavioural synchronous ROM and
// hand-computed note, address and handshake-timing expectations.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic        reset_player;
  logic [1:0]  song;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic        note_done;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;

  logic [11:0] mem [128];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          excl_viol = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  always @(negedge clk) if (new_note && song_done) excl_viol++;

  song_reader #(.NOTES_PER_SONG(32), .NOTE_W(6), .DUR_W(6)) dut (
    .clk(clk), .reset(reset), .play(play), .reset_player(reset_player),
    .song(song), .rom_addr(rom_addr), .rom_data(rom_data), .note_done(note_done),
    .note(note), .duration(duration), .new_note(new_note), .song_done(song_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until new_note (bounded); cyc counts edges, faddr is rom_addr after the first edge.
  task automatic wait_nn(output int cyc, output logic [6:0] faddr);
    cyc   = 0;
    faddr = '0;
    do begin
      tick();
      note_done    = 1'b0;
      reset_player = 1'b0;
      cyc++;
      if (cyc == 1) faddr = rom_addr;
    end while (!new_note && cyc < 20);
  endtask

  int         c;
  int         bad;
  int         cnt;
  logic [6:0] a;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]      = {6'(i + 1), 6'(i + 1)};
      mem[32 + i] = {6'(i + 1), 6'd3};
      mem[64 + i] = {6'(10 + i), 6'(i + 2)};
      mem[96 + i] = {6'(40 + i), 6'd5};
    end
    mem[32] = {6'd5, 6'd10};
    mem[33] = {6'd7, 6'd4};
    mem[69] = {6'd33, 6'd0};

    reset = 1'b0; play = 1'b1; song = 2'd0; reset_player = 1'b0; note_done = 1'b0;
    tick();
    tick();
    check("rst_note", note, 0);
    check("rst_dur", duration, 0);
    check("rst_new_note", new_note, 0);
    check("rst_song_done", song_done, 0);
    check("rst_addr", rom_addr, 0);
    reset = 1'b1;
    wait_nn(c, a);
    check("first_gap", c, 3);
    check("first_addr", a, 0);
    check("first_note", note, 1);
    check("first_dur", duration, 1);

    // Sequencing through song 1
    song = 2'd1;
    tick();
    wait_nn(c, a);
    check("s1n0_gap", c, 3);
    check("s1n0_addr", a, 32);
    check("s1n0_note", note, 5);
    check("s1n0_dur", duration, 10);
    note_done = 1'b1;
    wait_nn(c, a);
    check("s1n1_gap", c, 3);
    check("s1n1_addr", a, 33);
    check("s1n1_note", note, 7);
    check("s1n1_dur", duration, 4);
    note_done = 1'b1;
    wait_nn(c, a);
    check("s1n2_addr", a, 34);
    check("s1n2_note", note, 3);

    // Pause: note_done while play is low must be ignored
    play = 1'b0;
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    cnt = 0;
    repeat (6) begin tick(); if (new_note) cnt++; end
    check("pause_no_new_note", cnt, 0);
    check("pause_addr_held", rom_addr, 34);
    play = 1'b1;
    cnt = 0;
    repeat (2) begin tick(); if (new_note) cnt++; end
    check("resume_no_new_note", cnt, 0);
    note_done = 1'b1;
    wait_nn(c, a);
    check("resume_gap", c, 3);
    check("resume_addr", a, 35);
    check("resume_note", note, 4);

    // Full 32-note song
    song = 2'd0;
    tick();
    wait_nn(c, a);
    check("s0_first_gap", c, 3);
    bad = 0;
    for (int k = 1; k < 32; k++) begin
      note_done = 1'b1;
      wait_nn(c, a);
      if (c != 3 || a != 7'(k)) bad++;
    end
    check("s0_bad_steps", bad, 0);
    check("s0_last_note", note, 32);
    check("s0_last_addr", rom_addr, 31);
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    check("eos_song_done", song_done, 1);
    check("eos_new_note", new_note, 0);
    tick();
    check("eos_pulse_width", song_done, 0);
    cnt = 0;
    repeat (5) begin tick(); if (new_note || song_done) cnt++; end
    check("done_hold_pulses", cnt, 0);
    play = 1'b0;
    tick();
    tick();
    check("done_idle_addr", rom_addr, 0);
    play = 1'b1;
    wait_nn(c, a);
    check("replay_gap", c, 3);
    check("replay_note", note, 1);

    // End marker at song 2 slot 5
    song = 2'd2;
    tick();
    wait_nn(c, a);
    cnt = (c == 3 && new_note) ? 1 : 0;
    check("s2_first_note", note, 10);
    for (int k = 1; k < 5; k++) begin
      note_done = 1'b1;
      wait_nn(c, a);
      if (c == 3 && new_note) cnt++;
    end
    check("s2_new_note_count", cnt, 5);
    check("s2_note4", note, 14);
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    check("em_fetch_pulses", {new_note, song_done}, 0);
    tick();
    check("em_latch_pulses", {new_note, song_done}, 0);
    tick();
    check("em_song_done", song_done, 1);
    check("em_no_new_note", new_note, 0);
    check("em_note_kept", note, 14);
    check("em_dur_kept", duration, 6);
    tick();
    check("em_pulse_width", song_done, 0);
    cnt = 0;
    repeat (4) begin tick(); if (new_note) cnt++; end
    check("em_no_sixth", cnt, 0);
    play = 1'b0;
    tick();

    // Restart mid-song and song change
    song = 2'd0;
    play = 1'b1;
    tick();
    wait_nn(c, a);
    for (int k = 1; k < 10; k++) begin
      note_done = 1'b1;
      wait_nn(c, a);
    end
    check("pre_restart_addr", rom_addr, 9);
    reset_player = 1'b1;
    tick();
    reset_player = 1'b0;
    check("restart_addr", rom_addr, 0);
    check("restart_pulses", {new_note, song_done}, 0);
    wait_nn(c, a);
    check("restart_gap", c, 3);
    check("restart_note", note, 1);
    for (int k = 1; k < 5; k++) begin
      note_done = 1'b1;
      wait_nn(c, a);
    end
    check("pre_switch_addr", rom_addr, 4);
    song = 2'd3;
    tick();
    check("switch_addr", rom_addr, 96);
    check("switch_new_note", new_note, 0);
    wait_nn(c, a);
    check("switch_gap", c, 3);
    check("switch_fetch_addr", a, 96);
    check("switch_note", note, 40);

    check("pulse_exclusive", excl_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/song_reader.md
# song_reader

Sequencer on the far side of the `mcu` control interface. Consumes `play`, `reset_player` and `song[1:0]` from `mcu`. Steps through the selected song's note list in a synchronous ROM and hands each note to the note player with a `new_note`/`note_done` handshake. Returns a one-cycle `song_done` pulse to `mcu` when the song ends.

## Interface
- `NOTES_PER_SONG`, default 32: note slots per song (power of two); index width is log2(NOTES_PER_SONG).
- `NOTE_W`, default 6: note code width.
- `DUR_W`, default 6: duration field width.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `play` input 1: from `mcu`; 1 = run, 0 = pause.
- `reset_player` input 1: from `mcu`; synchronous restart of the current song.
- `song` input 2: from `mcu`; selected song 0..3.
- `rom_addr` output 2+log2(NOTES_PER_SONG): `{song, index}`, combinational from registered index and `song`.
- `rom_data` input NOTE_W+DUR_W: `{note, duration}`; synchronous ROM with 1-cycle read latency.
- `note_done` input 1: from the note player; single-cycle pulse when the current note finishes.
- `note` output NOTE_W: registered note code.
- `duration` output DUR_W: registered duration.
- `new_note` output 1: one-cycle pulse; `note`/`duration` are valid from that cycle on.
- `song_done` output 1: one-cycle pulse to `mcu` at end of song.

## Operation
- States:
  - IDLE: waiting for `play`.
  - FETCH: address presented to the ROM.
  - LATCH: ROM data captured.
  - WAIT_NOTE: waiting for `note_done`.
  - DONE: end of song reached.
- Reset (`reset` = 0 at an edge): state IDLE, index 0; `note`, `duration`, `new_note`, `song_done` all 0.
- Restart (`reset_player` = 1, or `song` differs from its value at the previous edge):
  - Next state IDLE, index 0, `new_note` = 0, `song_done` = 0.
  - Takes precedence over every transition except reset.
- IDLE: goes to FETCH when `play` = 1.
- FETCH: unconditionally goes to LATCH on the next edge, so `rom_addr` is held stable for one full cycle.
- LATCH, normal note (`rom_data` duration ≠ 0):
  - Register `note`/`duration` from `rom_data`.
  - Pulse `new_note` in the following cycle.
  - Go to WAIT_NOTE.
- LATCH, end marker (`rom_data` duration = 0):
  - No `new_note`; `note`/`duration` are unchanged.
  - Pulse `song_done` and go to DONE.
- WAIT_NOTE:
  - `note_done` is accepted only when `play` = 1. With `play` = 0 the block holds state and ignores `note_done`.
  - On an accepted `note_done` with index < NOTES_PER_SONG−1: index+1, go to FETCH.
  - On an accepted `note_done` with index = NOTES_PER_SONG−1: index ← 0, pulse `song_done`, go to DONE.
- DONE:
  - Holds until `play` = 0, then goes to IDLE with index 0.
  - A restart also exits DONE.
  - Re-playing therefore needs `play` to drop first, so there is no auto-replay while `mcu` reacts.
- Pause:
  - `play` = 0 in FETCH or LATCH does not abort the fetch; the block completes into WAIT_NOTE and waits there.
  - `play` = 0 in IDLE holds IDLE.
- Index arithmetic: unsigned, log2(NOTES_PER_SONG) bits. It never wraps by incrementing; the wrap to 0 happens only at DONE or on restart.

## Timing
- Edge E samples `play` = 1 in IDLE:
  - FETCH during cycle E+1.
  - LATCH during cycle E+2 (ROM data for `{song, index}` valid).
  - `new_note` = 1 during cycle E+3, with `note`/`duration` valid.
- `note_done` accepted at edge N (not the last note): FETCH at N+1, `new_note` during N+3. Note-to-note gap is 3 cycles.
- Last-note `note_done` at edge N: `song_done` = 1 during cycle N+1 only.
- End marker captured in LATCH at edge L: `song_done` = 1 during cycle L+1.
- `new_note` and `song_done` are never both 1. Each is exactly one cycle wide.
- Restart at edge R: all pulses are 0 from cycle R+1; the first note of the restarted song has `new_note` ≥3 cycles after `play` is seen in IDLE.
- `note_done` arriving in any state other than WAIT_NOTE is ignored.

## Test plan
- Reset: hold `reset` = 0 for 2 edges with `play` = 1 → `note` = 0, `duration` = 0, `new_note` = 0, `song_done` = 0, `rom_addr` = {song, 0}. Release with `play` = 1 → `new_note` 3 cycles later with ROM word 0 of song 0.
- Sequencing: song 1, ROM {note=5,dur=10}, {note=7,dur=4}, …; pulse `note_done` after each `new_note` → `rom_addr` = 32, 33, …; `note` = 5 then 7; gap of exactly 3 cycles from `note_done` to `new_note`.
- Pause: drop `play` during WAIT_NOTE of note 3, pulse `note_done` while paused → ignored, no `new_note`. Raise `play`, pulse `note_done` → note 4 fetched.
- End of song: fill all 32 slots with nonzero duration → after the 32nd `note_done`, one `song_done` pulse. Block holds in DONE while `play` = 1. Drop `play` → IDLE, index 0.
- End marker: song 2 slot 5 has duration = 0 → 5 `new_note` pulses, then `song_done` one cycle after LATCH of slot 5, no sixth `new_note`.
- Restart/song change: mid-song at index 9, pulse `reset_player` → IDLE, index 0, no pulses. Change `song` from 0 to 3 at index 4 → `rom_addr` = 96 at the next FETCH.
